sha256_compress_core: RTL
=========================

# sha256_compress_core

Iterative SHA-256 compression engine that consumes the rotate-by-constant stages (rotr 2/6/7/11/13/17/18/19/22/25) and applies one compression round per clock. It takes a 512-bit message block and a 256-bit chaining value, and runs the 64-round compression with an on-the-fly message schedule. It returns the updated chaining value with a one-cycle done pulse. It sits between the nonce/header formatter upstream and the double-hash sequencer and target comparator downstream.

## Interface
- No parameters. Round count is fixed at 64 and word width at 32.
- clock  in  1  Sole clock. All state updates on the rising edge.
- reset  in  1  Asynchronous, active-high. Clears all state.
- start  in  1  Request. Sampled only when busy=0.
- block_in  in  512  Message block. Word W0 = block_in[511:480], W15 = block_in[31:0] (big-endian word order).
- hash_in  in  256  Chaining value H0..H7. H0 = hash_in[255:224].
- hash_out  out  256  Result, same packing as hash_in. Held until the next completion or reset.
- busy  out  1  High while rounds are in progress.
- done  out  1  One-cycle pulse when hash_out is updated.

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE, start=1:
  - Latch hash_in into a..h and into an internal H copy.
  - Latch block_in into a 16-word schedule window.
  - Round counter t=0. Go to ROUND.
- IDLE, start=0: no state change.
- ROUND, each cycle:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
  - All sums are modulo 2^32; carries out of bit 31 are discarded.
- Function definitions:
  - Σ1(e) = rotr6 ^ rotr11 ^ rotr25
  - Σ0(a) = rotr2 ^ rotr13 ^ rotr22
  - σ0 = rotr7 ^ rotr18 ^ shr3
  - σ1 = rotr17 ^ rotr19 ^ shr10
  - rotrN(x)[i] = x[(i+N) mod 32] for every i in 0..31. It is a pure bit permutation: no duplicated or dropped bits.
  - shrN zero-fills the upper bits.
- Schedule window:
  - W[t] is window word 0.
  - Each round the window shifts down one word. The new word 15 is σ1(w14) + w9 + σ0(w1) + w0, taken from the pre-shift window.
  - The window keeps shifting for t ≥ 48 (unused values are harmless).
- K[0..63] is an internal 64×32 constant ROM indexed by t, holding the FIPS 180-4 constants.
- When t=63 completes, go to FINAL.
- FINAL:
  - hash_out ← {H0+a, …, H7+h}, each word modulo 2^32.
  - Assert done. Go to IDLE.
- start while busy=1 is ignored: no queueing, no restart. Inputs need only be stable at the accepting edge.

## Timing
- Reset values: hash_out=0, busy=0, done=0, state=IDLE, t=0. a..h, H copy and window are cleared to 0.
- Accept edge E0: start=1 and busy=0.
  - busy=1 from after E0.
  - Rounds occur on edges E1..E64.
  - FINAL edge E65 updates hash_out and sets done=1, busy=0.
  - done falls after E66.
- Latency: 65 cycles from the accept edge to hash_out valid.
- Back-to-back: start may be high during the done cycle. It is accepted at E66, giving an issue interval of 66 cycles.
- busy and done are never high together.
- Reset asserted mid-operation forces all reset values immediately. No done is generated, and the in-flight result is discarded.
- After reset deasserts, the first accepting edge behaves as E0.

## Test plan
- "abc" block (0x61626380, then zeros, last word 0x00000018) with the FIPS IV (6a09e667 … 5be0cd19) -> after 65 cycles hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, done pulses for exactly one cycle.
- Empty message (0x80000000, then zeros) with the IV -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two chained blocks of "abcdbcdecdefdefgefghfghighijhijkijkljklmnomnopnopq", with the block-1 result fed as hash_in on back-to-back start -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, second start accepted on the done cycle.
- Pulse start again at cycles 10 and 40 of a run with different block_in -> ignored; result equals the single-run value, exactly one done.
- Assert reset at cycle 30 of a run -> hash_out=0, busy=0 immediately, no done. A fresh "abc" run afterwards gives the correct digest.
- All-ones block and all-ones hash_in -> matches the reference-model result. This checks the 2^32 wrap in every adder and all 32 bits of each rotation (any misrouted rotr bit changes the digest).

Source files
------------

// File: rtl/sha256_compress_core.sv
// sha256_compress_core: iterative SHA-256 compression, one round per clock.
//   clock     in   1   rising-edge clock
//   reset     in   1   asynchronous active-high reset
//   start     in   1   request, sampled only while busy=0
//   block_in  in 512   message block, W0 = block_in[511:480]
//   hash_in   in 256   chaining value, H0 = hash_in[255:224]
//   hash_out  out 256  updated chaining value, held until next completion
//   busy      out  1   high while a block is in flight
//   done      out  1   one-cycle pulse when hash_out is updated
module sha256_compress_core (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic [255:0] hash_in,
    output logic [255:0] hash_out,
    output logic         busy,
    output logic         done
);

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned NUM_WIN  = 16;
    localparam int unsigned NUM_VARS = 8;
    localparam int unsigned T_W      = 6;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    // Fixed-amount rotations expressed as bit permutations
    function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    logic [1:0]        state_q, state_d;
    logic [T_W-1:0]    t_q, t_d;
    logic [WORD_W-1:0] wk_q  [NUM_VARS];   // working variables a..h at indices 0..7
    logic [WORD_W-1:0] wk_d  [NUM_VARS];
    logic [WORD_W-1:0] hc_q  [NUM_VARS];   // chaining value copy for the final add
    logic [WORD_W-1:0] hc_d  [NUM_VARS];
    logic [WORD_W-1:0] win_q [NUM_WIN];    // schedule window, word 0 is W[t]
    logic [WORD_W-1:0] win_d [NUM_WIN];
    logic [255:0]      hash_q, hash_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WORD_W-1:0] k_c;
    logic [WORD_W-1:0] ch_c, maj_c, t1_c, t2_c, w_new_c;

    // Round constant ROM
    always_comb begin
        k_c = 32'h0;
        case (t_q)
            6'd0:  k_c = 32'h428a2f98;  6'd1:  k_c = 32'h71374491;
            6'd2:  k_c = 32'hb5c0fbcf;  6'd3:  k_c = 32'he9b5dba5;
            6'd4:  k_c = 32'h3956c25b;  6'd5:  k_c = 32'h59f111f1;
            6'd6:  k_c = 32'h923f82a4;  6'd7:  k_c = 32'hab1c5ed5;
            6'd8:  k_c = 32'hd807aa98;  6'd9:  k_c = 32'h12835b01;
            6'd10: k_c = 32'h243185be;  6'd11: k_c = 32'h550c7dc3;
            6'd12: k_c = 32'h72be5d74;  6'd13: k_c = 32'h80deb1fe;
            6'd14: k_c = 32'h9bdc06a7;  6'd15: k_c = 32'hc19bf174;
            6'd16: k_c = 32'he49b69c1;  6'd17: k_c = 32'hefbe4786;
            6'd18: k_c = 32'h0fc19dc6;  6'd19: k_c = 32'h240ca1cc;
            6'd20: k_c = 32'h2de92c6f;  6'd21: k_c = 32'h4a7484aa;
            6'd22: k_c = 32'h5cb0a9dc;  6'd23: k_c = 32'h76f988da;
            6'd24: k_c = 32'h983e5152;  6'd25: k_c = 32'ha831c66d;
            6'd26: k_c = 32'hb00327c8;  6'd27: k_c = 32'hbf597fc7;
            6'd28: k_c = 32'hc6e00bf3;  6'd29: k_c = 32'hd5a79147;
            6'd30: k_c = 32'h06ca6351;  6'd31: k_c = 32'h14292967;
            6'd32: k_c = 32'h27b70a85;  6'd33: k_c = 32'h2e1b2138;
            6'd34: k_c = 32'h4d2c6dfc;  6'd35: k_c = 32'h53380d13;
            6'd36: k_c = 32'h650a7354;  6'd37: k_c = 32'h766a0abb;
            6'd38: k_c = 32'h81c2c92e;  6'd39: k_c = 32'h92722c85;
            6'd40: k_c = 32'ha2bfe8a1;  6'd41: k_c = 32'ha81a664b;
            6'd42: k_c = 32'hc24b8b70;  6'd43: k_c = 32'hc76c51a3;
            6'd44: k_c = 32'hd192e819;  6'd45: k_c = 32'hd6990624;
            6'd46: k_c = 32'hf40e3585;  6'd47: k_c = 32'h106aa070;
            6'd48: k_c = 32'h19a4c116;  6'd49: k_c = 32'h1e376c08;
            6'd50: k_c = 32'h2748774c;  6'd51: k_c = 32'h34b0bcb5;
            6'd52: k_c = 32'h391c0cb3;  6'd53: k_c = 32'h4ed8aa4a;
            6'd54: k_c = 32'h5b9cca4f;  6'd55: k_c = 32'h682e6ff3;
            6'd56: k_c = 32'h748f82ee;  6'd57: k_c = 32'h78a5636f;
            6'd58: k_c = 32'h84c87814;  6'd59: k_c = 32'h8cc70208;
            6'd60: k_c = 32'h90befffa;  6'd61: k_c = 32'ha4506ceb;
            6'd62: k_c = 32'hbef9a3f7;  6'd63: k_c = 32'hc67178f2;
            default: k_c = 32'h0;
        endcase
    end

    // Round datapath; sums wrap at 2^32 by width
    assign ch_c    = (wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]);
    assign maj_c   = (wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]);
    assign t1_c    = wk_q[7] + big_sigma1(wk_q[4]) + ch_c + k_c + win_q[0];
    assign t2_c    = big_sigma0(wk_q[0]) + maj_c;
    assign w_new_c = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        wk_d    = wk_q;
        hc_d    = hc_q;
        win_d   = win_q;
        hash_d  = hash_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_VARS; i++) begin
                        wk_d[i] = hash_in[255-32*i -: 32];
                        hc_d[i] = hash_in[255-32*i -: 32];
                    end
                    for (int i = 0; i < NUM_WIN; i++) begin
                        win_d[i] = block_in[511-32*i -: 32];
                    end
                    t_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                wk_d[7] = wk_q[6];
                wk_d[6] = wk_q[5];
                wk_d[5] = wk_q[4];
                wk_d[4] = wk_q[3] + t1_c;
                wk_d[3] = wk_q[2];
                wk_d[2] = wk_q[1];
                wk_d[1] = wk_q[0];
                wk_d[0] = t1_c + t2_c;
                for (int i = 0; i < NUM_WIN - 1; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[15] = w_new_c;
                t_d       = t_q + T_W'(1);
                if (t_q == T_W'(63)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                for (int i = 0; i < NUM_VARS; i++) begin
                    hash_d[255-32*i -: 32] = hc_q[i] + wk_q[i];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            hash_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_VARS; i++) begin
                wk_q[i] <= '0;
                hc_q[i] <= '0;
            end
            for (int i = 0; i < NUM_WIN; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            hash_q  <= hash_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < NUM_VARS; i++) begin
                wk_q[i] <= wk_d[i];
                hc_q[i] <= hc_d[i];
            end
            for (int i = 0; i < NUM_WIN; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign hash_out = hash_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
